// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the MEM stage: bus widths, bus layout, load codes, FSM states.
package mem_stage_pkg;

    localparam int EXE_MEM_BUS_W = 107;
    localparam int MEM_WB_BUS_W  = 102;
    localparam int MEM_ID_BUS_W  = 39;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_H  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        res_from_mem;
        logic [2:0]  load_type;
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu_result;
        logic [4:0]  dest;
        logic        mem_req;
    } exe_mem_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and sign/zero extension.
// Sub-word selection exists only when MEM_SUBWORD_LOAD_EN is defined; otherwise the word passes through.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);
`ifdef MEM_SUBWORD_LOAD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        // Unknown load codes fall back to a full-word load.
        case (load_type)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
`else
    logic unused_sel;

    assign unused_sel = ^{addr, load_type};
    assign data       = rdata;
`endif
endmodule

// File: rtl/mem_stage.sv
// Memory access stage: EMPTY/WAIT/READY handshake between EX, the data SRAM response and WB.
// Sub-word load extension is enabled by defining MEM_SUBWORD_LOAD_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exe_mem_valid,
    output logic                     mem_allowin,
    input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
    input  logic                     data_sram_data_ok,
    input  logic [31:0]              data_sram_rdata,
    input  logic                     wb_allowin,
    output logic                     mem_wb_valid,
    output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus,
    output logic [MEM_ID_BUS_W-1:0]  mem_id_bus
);
    mem_state_e   state_q, state_d;
    exe_mem_bus_t bus_q, bus_d, in_bus;
    logic [31:0]  hold_q, hold_d;
    logic         in_wait, mem_ready_go, accept;
    logic [31:0]  load_raw, load_data, final_result;
    logic         unused_mem_req;

    assign in_bus       = exe_mem_bus_t'(exe_mem_bus);
    assign in_wait      = (state_q == S_WAIT);
    assign mem_ready_go = (state_q == S_READY) | (in_wait & data_sram_data_ok);
    assign mem_allowin  = (state_q == S_EMPTY) | (mem_ready_go & wb_allowin);
    assign mem_wb_valid = mem_ready_go;
    assign accept       = exe_mem_valid & mem_allowin;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d = in_bus.mem_req ? S_WAIT : S_READY;
            bus_d   = in_bus;
        end else if (mem_ready_go && wb_allowin) begin
            state_d = S_EMPTY;
        end else if (in_wait && data_sram_data_ok) begin
            // WB stalled on the response cycle: capture the data, it will not be presented again.
            state_d = S_READY;
            hold_d  = data_sram_rdata;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    // NOTE: payload registers are left unreset; they are only observed while state_q != S_EMPTY.
    always_ff @(posedge clk) begin
        bus_q  <= bus_d;
        hold_q <= hold_d;
    end

    assign load_raw = in_wait ? data_sram_rdata : hold_q;

    load_align u_load_align (
        .rdata     (load_raw),
        .addr      (bus_q.alu_result[1:0]),
        .load_type (bus_q.load_type),
        .data      (load_data)
    );

    assign final_result   = bus_q.res_from_mem ? load_data : bus_q.alu_result;
    assign mem_wb_bus     = {bus_q.gr_we, bus_q.pc, bus_q.inst, final_result, bus_q.dest};
    assign mem_id_bus     = {(state_q != S_EMPTY) & bus_q.gr_we,
                             bus_q.dest,
                             final_result,
                             in_wait & bus_q.res_from_mem & ~data_sram_data_ok};
    assign unused_mem_req = bus_q.mem_req;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage; expected load results follow MEM_SUBWORD_LOAD_EN.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         exe_mem_valid;
    logic         mem_allowin;
    logic [106:0] exe_mem_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_allowin;
    logic         mem_wb_valid;
    logic [101:0] mem_wb_bus;
    logic [38:0]  mem_id_bus;

    int checks = 0;
    int errors = 0;

`ifdef MEM_SUBWORD_LOAD_EN
    localparam logic [31:0] EXP_LDB  = 32'hFFFF_FF80;
    localparam logic [31:0] EXP_LDHU = 32'h0000_BEEF;
`else
    localparam logic [31:0] EXP_LDB  = 32'h0080_7F00;
    localparam logic [31:0] EXP_LDHU = 32'hBEEF_1234;
`endif

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .exe_mem_valid     (exe_mem_valid),
        .mem_allowin       (mem_allowin),
        .exe_mem_bus       (exe_mem_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_allowin        (wb_allowin),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_bus        (mem_wb_bus),
        .mem_id_bus        (mem_id_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output field views
    wire        wb_gr_we   = mem_wb_bus[101];
    wire [31:0] wb_pc      = mem_wb_bus[100:69];
    wire [31:0] wb_final   = mem_wb_bus[36:5];
    wire [4:0]  wb_dest    = mem_wb_bus[4:0];
    wire        id_fwd_we  = mem_id_bus[38];
    wire [4:0]  id_dest    = mem_id_bus[37:33];
    wire [31:0] id_final   = mem_id_bus[32:1];
    wire        id_pending = mem_id_bus[0];

    function automatic logic [106:0] mk_bus(input logic res_from_mem, input logic [2:0] load_type,
                                            input logic gr_we, input logic [31:0] pc,
                                            input logic [31:0] alu, input logic [4:0] dest,
                                            input logic mem_req);
        return {res_from_mem, load_type, gr_we, pc, 32'h0280_0000 ^ pc, alu, dest, mem_req};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exe_mem_valid = 1'b0;
        exe_mem_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        wb_allowin = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1 || id_fwd_we !== 1'b0 || id_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b allowin=%b fwd_we=%b pending=%b, want 0 1 0 0",
                     mem_wb_valid, mem_allowin, id_fwd_we, id_pending);
        end
    endtask

    task automatic test_alu_op();
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b0, 3'd0, 1'b1, 32'h1c00_0000, 32'h1234_5678, 5'd5, 1'b0);
        step();
        exe_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || wb_final !== 32'h1234_5678 || wb_dest !== 5'd5 ||
            wb_gr_we !== 1'b1 || wb_pc !== 32'h1c00_0000) begin
            errors++;
            $display("FAIL alu_op: valid=%b final=%h dest=%0d we=%b pc=%h, want 1 12345678 5 1 1c000000",
                     mem_wb_valid, wb_final, wb_dest, wb_gr_we, wb_pc);
        end
        checks++;
        if (id_fwd_we !== 1'b1 || id_dest !== 5'd5 || id_final !== 32'h1234_5678 || id_pending !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd: fwd_we=%b dest=%0d final=%h pending=%b, want 1 5 12345678 0",
                     id_fwd_we, id_dest, id_final, id_pending);
        end
        step();
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++;
            $display("FAIL alu_drain: valid=%b allowin=%b, want 0 1", mem_wb_valid, mem_allowin);
        end
    endtask

    task automatic test_load_byte();
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b1, 3'd1, 1'b1, 32'h1c00_0010, 32'h1c00_1002, 5'd7, 1'b1);
        step();
        exe_mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || id_pending !== 1'b1 || mem_allowin !== 1'b0 || id_fwd_we !== 1'b1) begin
            errors++;
            $display("FAIL ldb_wait: valid=%b pending=%b allowin=%b fwd_we=%b, want 0 1 0 1",
                     mem_wb_valid, id_pending, mem_allowin, id_fwd_we);
        end
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0080_7F00;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || wb_final !== EXP_LDB || id_pending !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++;
            $display("FAIL ldb_data: valid=%b final=%h pending=%b allowin=%b, want 1 %h 0 1",
                     mem_wb_valid, wb_final, id_pending, mem_allowin, EXP_LDB);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++;
            $display("FAIL ldb_drain: valid=%b allowin=%b, want 0 1", mem_wb_valid, mem_allowin);
        end
    endtask

    task automatic test_load_half_stall();
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b1, 3'd4, 1'b1, 32'h1c00_0020, 32'h1c00_2002, 5'd9, 1'b1);
        step();
        exe_mem_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        wb_allowin = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b0 || wb_final !== EXP_LDHU) begin
            errors++;
            $display("FAIL ldhu_resp: valid=%b allowin=%b final=%h, want 1 0 %h",
                     mem_wb_valid, mem_allowin, wb_final, EXP_LDHU);
        end
        // Held in READY: a stray data_ok with garbage data must be ignored.
        step();
        data_sram_rdata = 32'hDEAD_DEAD;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b0 || wb_final !== EXP_LDHU || id_pending !== 1'b0) begin
            errors++;
            $display("FAIL ldhu_hold: valid=%b allowin=%b final=%h pending=%b, want 1 0 %h 0",
                     mem_wb_valid, mem_allowin, wb_final, id_pending, EXP_LDHU);
        end
        step();
        data_sram_data_ok = 1'b0;
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b1 || wb_final !== EXP_LDHU) begin
            errors++;
            $display("FAIL ldhu_handoff: valid=%b allowin=%b final=%h, want 1 1 %h",
                     mem_wb_valid, mem_allowin, wb_final, EXP_LDHU);
        end
        step();
        checks++;
        if (mem_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL ldhu_drain: valid=%b, want 0", mem_wb_valid);
        end
    endtask

    task automatic test_store();
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b0, 3'd0, 1'b0, 32'h1c00_0030, 32'h1c00_3000, 5'd0, 1'b1);
        step();
        exe_mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b0 || id_pending !== 1'b0 || id_fwd_we !== 1'b0) begin
                errors++;
                $display("FAIL st_wait[%0d]: valid=%b allowin=%b pending=%b fwd_we=%b, want 0 0 0 0",
                         i, mem_wb_valid, mem_allowin, id_pending, id_fwd_we);
            end
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_AAAA;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b1 || wb_gr_we !== 1'b0 || wb_final !== 32'h1c00_3000) begin
            errors++;
            $display("FAIL st_done: valid=%b we=%b final=%h, want 1 0 1c003000",
                     mem_wb_valid, wb_gr_we, wb_final);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_drain: valid=%b, want 0", mem_wb_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b1, 3'd0, 1'b1, 32'h1c00_0040, 32'h1c00_4000, 5'd3, 1'b1);
        step();
        exe_mem_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0BAD_F00D;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1 || id_fwd_we !== 1'b0 || id_pending !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: valid=%b allowin=%b fwd_we=%b pending=%b, want 0 1 0 0",
                     mem_wb_valid, mem_allowin, id_fwd_we, id_pending);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++;
            $display("FAIL rst_after: valid=%b allowin=%b, want 0 1", mem_wb_valid, mem_allowin);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc_i, alu_i;
        exe_mem_valid = 1'b1;
        exe_mem_bus = mk_bus(1'b0, 3'd0, 1'b1, 32'h1c00_0100, 32'h0000_1000, 5'd1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                pc_i  = 32'h1c00_0100 + 32'(4 * i);
                alu_i = 32'h0000_1000 + 32'(i);
                exe_mem_bus = mk_bus(1'b0, 3'd0, 1'b1, pc_i, alu_i, 5'(i + 1), 1'b0);
            end else begin
                exe_mem_valid = 1'b0;
            end
            #1;
            checks++;
            if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b1 ||
                wb_pc !== 32'h1c00_0100 + 32'(4 * (i - 1)) ||
                wb_final !== 32'h0000_1000 + 32'(i - 1) || wb_dest !== 5'(i)) begin
                errors++;
                $display("FAIL b2b[%0d]: valid=%b allowin=%b pc=%h final=%h dest=%0d, want 1 1 %h %h %0d",
                         i - 1, mem_wb_valid, mem_allowin, wb_pc, wb_final, wb_dest,
                         32'h1c00_0100 + 32'(4 * (i - 1)), 32'h0000_1000 + 32'(i - 1), i);
            end
        end
        step();
        checks++;
        if (mem_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", mem_wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_load_half_stall();
        test_store();
        test_reset_in_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
